regfile_access_ctrl: RTL
========================

// Module: regfile_access_ctrl
// PURPOSE
//   Schedules all traffic into the 2-read/1-write register file. Arbitrates two
//   write-back requesters (wb0 = ALU, wb1 = load unit) and one dual-address read
//   requester (decode) onto the single shared access slot each cycle.
//   Enforces read-after-write ordering, keeps x0 hard-wired to zero, and
//   sequences the register file's synchronous clear after reset.
// PARAMETERS
//   DATA_WIDTH_P    32  register data width
//   ADDR_WIDTH_P    5   register address width
//   STARVE_LIMIT_P  4   consecutive write-granted cycles a ready read may lose before it is forced
//   INIT_CYCLES_P   2   cycles o_rf_reset is held high after reset release (>=1)
// PORTS
//   clk             in   1    clock
//   reset           in   1    asynchronous, active-high reset
//   i_rd_valid      in   1    read request valid
//   o_rd_ready      out  1    read request accepted (issued to register file) this cycle
//   i_rd_addr_a/_b  in   AW   read addresses (stable while i_rd_valid high)
//   o_rd_data_valid out  1    read data valid (one-cycle pulse, no backpressure)
//   o_rd_data_a/_b  out  DW   read data (pass-through of i_rf_rd_data_a/_b)
//   i_wbN_valid     in   1    write request valid, N = 0,1
//   o_wbN_ready     out  1    write request granted
//   i_wbN_addr      in   AW   write address
//   i_wbN_data      in   DW   write data
//   o_rf_reset      out  1    synchronous clear to register file
//   o_rf_rd_addr_a/_b out AW  register file read addresses
//   o_rf_wr_enable  out  1    register file write enable
//   o_rf_wr_addr    out  AW   register file write address
//   o_rf_wr_data    out  DW   register file write data
//   i_rf_rd_data_a/_b in DW   register file read data
// BEHAVIOUR
//   - Register file reads only in cycles with wr_enable low; each cycle carries a read OR a write, never both.
//   - Handshake: transfer when valid && ready in the same cycle. Readies depend combinationally on valids;
//     requesters must not derive valid from ready. Requests hold addr/data stable until accepted.
//   - FSM: INIT -> RUN. INIT is entered on reset: o_rf_reset=1, all readies 0, o_rf_wr_enable=0.
//     A counter holds INIT for INIT_CYCLES_P cycles after reset release, then moves to RUN (o_rf_reset=0).
//   - Outputs during reset/INIT: o_rd_ready=0, o_wb0_ready=0, o_wb1_ready=0, o_rd_data_valid=0,
//     o_rf_wr_enable=0, o_rf_reset=1. Round-robin pointer resets to wb0; starvation counter resets to 0.
//   - RUN, per cycle:
//     hazard = i_rd_valid && a wbN valid with addr!=0 and addr == i_rd_addr_a or i_rd_addr_b.
//     read_ok = i_rd_valid && !hazard.
//     force = read_ok && starve_cnt == STARVE_LIMIT_P.
//     If any wb valid and !force: grant one write (RR below); else if read_ok: issue read.
//   - RR: if both wb valid, grant the preferred source; after any grant, preference moves to the other source.
//   - Write with addr 0: acknowledged (ready=1) but o_rf_wr_enable=0; still occupies the slot (no read issued).
//   - o_rf_wr_addr/o_rf_wr_data are muxed from the granted source; they are don't-care when wr_enable=0.
//   - o_rf_rd_addr_* = i_rd_addr_* combinationally. o_rd_data_valid is registered, 1 cycle after read issue.
//   - Read latency: 1 cycle. Data is valid for the o_rd_data_valid cycle only.
//   - starve_cnt: +1 (saturating at STARVE_LIMIT_P) when read_ok and a write is granted.
//     Cleared when a read issues or read_ok=0.
//   - Hazarded reads wait indefinitely; writes always drain, so no deadlock.
//   - Async reset mid-operation: drops all grants immediately, kills a pending o_rd_data_valid, re-enters INIT.
// TESTING
//   1 reset 3 cycles then release -> o_rf_reset high exactly INIT_CYCLES_P=2 cycles after release; all readies 0 until RUN
//   2 wb0 write x5=0xDEADBEEF, then read a=5,b=0 -> wr_enable 1 cycle; next cycle read issues;
//     o_rd_data_valid 1 cycle later with a=0xDEADBEEF, b=0
//   3 wb0 and wb1 valid continuously for 4 cycles -> grants alternate wb0,wb1,wb0,wb1
//   4 read a=7 while wb1 x7 pending, plus wb0 streaming -> read blocked until wb1 x7 written; then it returns the new value
//   5 read a=3 (no hazard) with wb0 streaming every cycle -> 4 writes granted, 5th cycle read forced, o_wb0_ready=0 that cycle
//   6 wb1 write x0=0x1234 -> o_wb1_ready=1, o_rf_wr_enable=0; a subsequent read of x0 returns 0

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Bundle of every signal between the access controller, its three requesters and the register file.
// Handshake: a request transfers in any cycle where valid && ready are both high; ready may depend
// combinationally on valid, valid must never depend on ready, and addr/data hold until the transfer.
interface regfile_access_ctrl_if #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5
);
    logic                    i_rd_valid;
    logic                    o_rd_ready;
    logic [ADDR_WIDTH_P-1:0] i_rd_addr_a;
    logic [ADDR_WIDTH_P-1:0] i_rd_addr_b;
    logic                    o_rd_data_valid;
    logic [DATA_WIDTH_P-1:0] o_rd_data_a;
    logic [DATA_WIDTH_P-1:0] o_rd_data_b;

    logic                    i_wb0_valid;
    logic                    o_wb0_ready;
    logic [ADDR_WIDTH_P-1:0] i_wb0_addr;
    logic [DATA_WIDTH_P-1:0] i_wb0_data;

    logic                    i_wb1_valid;
    logic                    o_wb1_ready;
    logic [ADDR_WIDTH_P-1:0] i_wb1_addr;
    logic [DATA_WIDTH_P-1:0] i_wb1_data;

    logic                    o_rf_reset;
    logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_a;
    logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_b;
    logic                    o_rf_wr_enable;
    logic [ADDR_WIDTH_P-1:0] o_rf_wr_addr;
    logic [DATA_WIDTH_P-1:0] o_rf_wr_data;
    logic [DATA_WIDTH_P-1:0] i_rf_rd_data_a;
    logic [DATA_WIDTH_P-1:0] i_rf_rd_data_b;

    modport slave (
        input  i_rd_valid, i_rd_addr_a, i_rd_addr_b,
        input  i_wb0_valid, i_wb0_addr, i_wb0_data,
        input  i_wb1_valid, i_wb1_addr, i_wb1_data,
        input  i_rf_rd_data_a, i_rf_rd_data_b,
        output o_rd_ready, o_rd_data_valid, o_rd_data_a, o_rd_data_b,
        output o_wb0_ready, o_wb1_ready,
        output o_rf_reset, o_rf_rd_addr_a, o_rf_rd_addr_b,
        output o_rf_wr_enable, o_rf_wr_addr, o_rf_wr_data
    );

    modport master (
        output i_rd_valid, i_rd_addr_a, i_rd_addr_b,
        output i_wb0_valid, i_wb0_addr, i_wb0_data,
        output i_wb1_valid, i_wb1_addr, i_wb1_data,
        output i_rf_rd_data_a, i_rf_rd_data_b,
        input  o_rd_ready, o_rd_data_valid, o_rd_data_a, o_rd_data_b,
        input  o_wb0_ready, o_wb1_ready,
        input  o_rf_reset, o_rf_rd_addr_a, o_rf_rd_addr_b,
        input  o_rf_wr_enable, o_rf_wr_addr, o_rf_wr_data
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Single-slot scheduler for a 2R/1W register file: round-robin write-back arbitration, RAW hazard
// blocking, read starvation forcing, x0 write suppression and post-reset clear sequencing.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH_P   = 32,
    parameter int ADDR_WIDTH_P   = 5,
    parameter int STARVE_LIMIT_P = 4,
    parameter int INIT_CYCLES_P  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_access_ctrl_if.slave bus,
    output logic                 dbg_state
);
    localparam int SW = $clog2(STARVE_LIMIT_P + 1);
    localparam int IW = (INIT_CYCLES_P > 1) ? $clog2(INIT_CYCLES_P) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT_P);
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES_P - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [IW-1:0]           init_cnt;
    logic [SW-1:0]           starve_cnt;
    logic                    pref_wb1;
    logic                    rf_reset;
    logic                    rd_data_valid;

    logic                    run;
    logic                    hit0;
    logic                    hit1;
    logic                    hazard;
    logic                    read_ok;
    logic                    force_rd;
    logic                    grant_wr;
    logic                    sel_wb1;
    logic                    issue_rd;
    logic [ADDR_WIDTH_P-1:0] wr_addr;
    logic [DATA_WIDTH_P-1:0] wr_data;

    always_comb begin
        run      = (state == ST_RUN);
        // x0 writes never create a hazard since x0 always reads as zero.
        hit0     = bus.i_wb0_valid && (bus.i_wb0_addr != '0) &&
                   ((bus.i_wb0_addr == bus.i_rd_addr_a) || (bus.i_wb0_addr == bus.i_rd_addr_b));
        hit1     = bus.i_wb1_valid && (bus.i_wb1_addr != '0) &&
                   ((bus.i_wb1_addr == bus.i_rd_addr_a) || (bus.i_wb1_addr == bus.i_rd_addr_b));
        hazard   = bus.i_rd_valid && (hit0 || hit1);
        read_ok  = bus.i_rd_valid && !hazard;
        force_rd = read_ok && (starve_cnt == STARVE_MAX);
        grant_wr = run && (bus.i_wb0_valid || bus.i_wb1_valid) && !force_rd;
        sel_wb1  = bus.i_wb1_valid && (!bus.i_wb0_valid || pref_wb1);
        issue_rd = run && read_ok && !grant_wr;
        wr_addr  = sel_wb1 ? bus.i_wb1_addr : bus.i_wb0_addr;
        wr_data  = sel_wb1 ? bus.i_wb1_data : bus.i_wb0_data;
    end

    assign bus.o_rd_ready      = issue_rd;
    assign bus.o_wb0_ready     = grant_wr && !sel_wb1;
    assign bus.o_wb1_ready     = grant_wr && sel_wb1;
    assign bus.o_rf_wr_enable  = grant_wr && (wr_addr != '0);
    assign bus.o_rf_wr_addr    = wr_addr;
    assign bus.o_rf_wr_data    = wr_data;
    assign bus.o_rf_rd_addr_a  = bus.i_rd_addr_a;
    assign bus.o_rf_rd_addr_b  = bus.i_rd_addr_b;
    assign bus.o_rd_data_a     = bus.i_rf_rd_data_a;
    assign bus.o_rd_data_b     = bus.i_rf_rd_data_b;
    assign bus.o_rd_data_valid = rd_data_valid;
    assign bus.o_rf_reset      = rf_reset;
    assign dbg_state           = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_INIT;
            init_cnt      <= '0;
            starve_cnt    <= '0;
            pref_wb1      <= 1'b0;
            rf_reset      <= 1'b1;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= issue_rd;
            case (state)
                ST_INIT: begin
                    starve_cnt <= '0;
                    pref_wb1   <= 1'b0;
                    if (init_cnt == INIT_LAST) begin
                        state    <= ST_RUN;
                        rf_reset <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant_wr) begin
                        pref_wb1 <= !sel_wb1;
                    end
                    // Counts only cycles where an issuable read lost the slot to a write.
                    if (read_ok && grant_wr) begin
                        if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                    rf_reset <= 1'b1;
                end
            endcase
        end
    end
endmodule
